// File: rtl/hdmi_pll_reset_seq_pkg.sv
// Shared types for the HDMI PLL reset/lock sequencer: state encoding, widths,
// and the state-to-output decode used by the registered output stage.
package hdmi_pll_seq_pkg;

    localparam int RETRY_W  = 3;
    localparam int RELOCK_W = 8;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } seq_state_e;

    typedef struct packed {
        logic pll_rst;
        logic sys_rst;
        logic ready;
        logic fault;
    } seq_out_t;

    // PLL is only held in reset during the pulse phase; sys_rst is released only in S_RUN.
    function automatic seq_out_t decode_out(input seq_state_e s);
        seq_out_t o;
        o.pll_rst = (s == S_PLL_RST);
        o.sys_rst = (s != S_RUN);
        o.ready   = (s == S_RUN);
        o.fault   = (s == S_FAULT);
        return o;
    endfunction

endpackage

// File: rtl/hdmi_pll_reset_seq_if.sv
// PLL reset/locked handshake plus sequencer status, as seen by the sequencer (master).
// relock_count exists only when PLL_RELOCK_STATS_EN is defined.
interface hdmi_pll_reset_seq_if;
    import hdmi_pll_seq_pkg::*;

    logic               pll_locked;
    logic               pll_rst;
    logic               sys_rst;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_count;
`ifdef PLL_RELOCK_STATS_EN
    logic [RELOCK_W-1:0] relock_count;

    modport master (
        input  pll_locked,
        output pll_rst, sys_rst, ready, fault, retry_count, relock_count
    );
    modport slave (
        output pll_locked,
        input  pll_rst, sys_rst, ready, fault, retry_count, relock_count
    );
`else
    modport master (
        input  pll_locked,
        output pll_rst, sys_rst, ready, fault, retry_count
    );
    modport slave (
        output pll_locked,
        input  pll_rst, sys_rst, ready, fault, retry_count
    );
`endif

endinterface

// File: rtl/hdmi_pll_reset_seq_sync.sv
// Reset-free two-flop synchroniser for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic [1:0] sync_pipe;

    always_ff @(posedge clk)
        sync_pipe <= {sync_pipe[0], d};

    assign q = sync_pipe[1];

endmodule

// File: rtl/hdmi_pll_reset_seq.sv
// HDMI PLL reset/lock sequencer on the PLL reference clock. Optional relock
// statistics counter and port are built when PLL_RELOCK_STATS_EN is defined.
module hdmi_pll_reset_seq
    import hdmi_pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_W               = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hdmi_pll_reset_seq_if.master bus
);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    logic               locked_s;
    seq_state_e         state, nxt;
    logic [CNT_W-1:0]   timer;
    logic [RETRY_W-1:0] retry_q, retry_nxt;
    seq_out_t           out_q;

    sync_2ff u_lock_sync (
        .clk (clk),
        .d   (bus.pll_locked),
        .q   (locked_s)
    );

    // Lock is tested before the timeout so a lock seen on the timeout cycle wins.
    always_comb begin
        nxt       = state;
        retry_nxt = retry_q;
        unique case (state)
            S_PLL_RST:   if (timer == RST_LAST) nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    nxt = S_STABLE;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_nxt = retry_q + 1'b1;
                    nxt       = (retry_nxt == RETRY_MAX) ? S_FAULT : S_PLL_RST;
                end
            end
            S_STABLE: begin
                if (!locked_s)                nxt = S_WAIT_LOCK;
                else if (timer == STABLE_LAST) nxt = S_RUN;
            end
            S_RUN:       if (!locked_s) nxt = S_PLL_RST;
            S_FAULT:     nxt = S_FAULT;
            default:     nxt = S_PLL_RST;
        endcase
        if (nxt == S_RUN) retry_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_PLL_RST;
            timer   <= '0;
            retry_q <= '0;
            out_q   <= decode_out(S_PLL_RST);
        end else begin
            state   <= nxt;
            retry_q <= retry_nxt;
            out_q   <= decode_out(nxt);
            // Timer only runs in the timed phases; RUN and FAULT hold it.
            if (nxt != state)
                timer <= '0;
            else if (state == S_PLL_RST || state == S_WAIT_LOCK || state == S_STABLE)
                timer <= timer + 1'b1;
        end
    end

    assign bus.pll_rst     = out_q.pll_rst;
    assign bus.sys_rst     = out_q.sys_rst;
    assign bus.ready       = out_q.ready;
    assign bus.fault       = out_q.fault;
    assign bus.retry_count = retry_q;

`ifdef PLL_RELOCK_STATS_EN
    logic [RELOCK_W-1:0] relock_q;

    always_ff @(posedge clk) begin
        if (rst)
            relock_q <= '0;
        else if (state == S_RUN && nxt == S_PLL_RST && relock_q != '1)
            relock_q <= relock_q + 1'b1;
    end

    assign bus.relock_count = relock_q;
`endif

endmodule

// File: tb/tb_hdmi_pll_reset_seq.sv
// Bench for hdmi_pll_reset_seq: directed timing checks plus randomized lock
// traffic compared every cycle against a phase/countdown reference model.
module tb_hdmi_pll_reset_seq;

    localparam int RP = 4;
    localparam int ST = 8;
    localparam int TO = 32;
    localparam int MR = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hdmi_pll_reset_seq_if bus();

    hdmi_pll_reset_seq #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_STABLE_CYCLES  (ST),
        .LOCK_TIMEOUT_CYCLES (TO),
        .MAX_RETRIES         (MR),
        .CNT_W               (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: phase plus cycles-left countdown, lock seen two edges late.
    typedef enum {M_RST, M_WAIT, M_STAB, M_RUN, M_FAULT} ph_e;
    ph_e  ph = M_RST;
    int   left = RP;
    int   m_retry = 0;
    int   m_relock = 0;
    logic samp[$];

    task automatic enter(input ph_e p);
        ph = p;
        case (p)
            M_RST:   left = RP;
            M_WAIT:  left = TO;
            M_STAB:  left = ST;
            default: left = 0;
        endcase
    endtask

    task automatic model_step(input logic ls);
        case (ph)
            M_RST: begin
                left--;
                if (left == 0) enter(M_WAIT);
            end
            M_WAIT: begin
                if (ls) enter(M_STAB);
                else begin
                    left--;
                    if (left == 0) begin
                        m_retry++;
                        enter((m_retry == MR) ? M_FAULT : M_RST);
                    end
                end
            end
            M_STAB: begin
                if (!ls) enter(M_WAIT);
                else begin
                    left--;
                    if (left == 0) begin
                        enter(M_RUN);
                        m_retry = 0;
                    end
                end
            end
            M_RUN: begin
                if (!ls) begin
                    enter(M_RST);
                    if (m_relock < 255) m_relock++;
                end
            end
            default: ;
        endcase
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge, compare 1 later.
    task automatic tick(input logic lk, input logic r);
        logic ls;
        @(negedge clk);
        bus.pll_locked = lk;
        rst = r;
        @(posedge clk);
        samp.push_back(lk);
        if (samp.size() > 3) void'(samp.pop_front());
        ls = (samp.size() == 3) ? samp[0] : 1'b0;
        if (r) begin
            enter(M_RST);
            m_retry  = 0;
            m_relock = 0;
        end else begin
            model_step(ls);
        end
        #1;
        chk("m_pll_rst", bus.pll_rst, (ph == M_RST));
        chk("m_sys_rst", bus.sys_rst, (ph != M_RUN));
        chk("m_ready",   bus.ready,   (ph == M_RUN));
        chk("m_fault",   bus.fault,   (ph == M_FAULT));
        chk("m_retry",   bus.retry_count, m_retry);
`ifdef PLL_RELOCK_STATS_EN
        chk("m_relock",  bus.relock_count, m_relock);
`endif
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, bus.pll_rst, 1);
        chk({tag, "_sys_rst"}, bus.sys_rst, 1);
        chk({tag, "_ready"},   bus.ready, 0);
        chk({tag, "_fault"},   bus.fault, 0);
        chk({tag, "_retry"},   bus.retry_count, 0);
    endtask

    int n_hit;

    initial begin
        rst = 1'b1;
        bus.pll_locked = 1'b0;
        repeat (3) tick(1'b0, 1'b1);
        chk_reset_vals("por");

        // PLL rst pulse: drops on the 4th edge after release.
        n_hit = 0;
        for (int n = 1; n <= 20; n++) begin
            tick(1'b0, 1'b0);
            if (!bus.pll_rst) begin n_hit = n; break; end
        end
        chk("rst_pulse_len", n_hit, RP);

        // Lock held: ready on the 11th edge counting the one that samples lock.
        repeat (5) tick(1'b0, 1'b0);
        n_hit = 0;
        for (int n = 1; n <= 40; n++) begin
            tick(1'b1, 1'b0);
            if (bus.ready) begin n_hit = n; break; end
        end
        chk("lock_to_ready", n_hit, ST + 3);
        chk("run_sys_rst", bus.sys_rst, 0);
        chk("run_pll_rst", bus.pll_rst, 0);

        // Loss of lock in RUN: sys_rst back on the 3rd edge, then a 4-clk PLL pulse, relock.
        n_hit = 0;
        for (int n = 1; n <= 10; n++) begin
            tick(1'b0, 1'b0);
            if (bus.sys_rst) begin n_hit = n; break; end
        end
        chk("drop_to_sys_rst", n_hit, 3);
        chk("drop_ready", bus.ready, 0);
        chk("drop_pll_rst", bus.pll_rst, 1);
        n_hit = 0;
        for (int n = 1; n <= 20; n++) begin
            tick(1'b1, 1'b0);
            if (!bus.pll_rst) begin n_hit = n; break; end
        end
        chk("relock_pulse_len", n_hit, RP);
        for (int n = 1; n <= 40; n++) begin
            tick(1'b1, 1'b0);
            if (bus.ready) break;
        end
        chk("relock_ready", bus.ready, 1);
`ifdef PLL_RELOCK_STATS_EN
        chk("relock_count", bus.relock_count, 1);
`endif

        // One-cycle glitch after 6 stable highs restarts qualification: ready on edge 19.
        repeat (2) tick(1'b0, 1'b1);
        repeat (RP) tick(1'b0, 1'b0);
        n_hit = 0;
        for (int n = 1; n <= 60; n++) begin
            tick((n == 8) ? 1'b0 : 1'b1, 1'b0);
            if (bus.ready) begin n_hit = n; break; end
        end
        chk("glitch_to_ready", n_hit, 19);
        chk("glitch_retry", bus.retry_count, 0);

        // rst asserted while qualifying lock.
        repeat (2) tick(1'b0, 1'b1);
        repeat (RP) tick(1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk_reset_vals("rst_stable");

        // No lock ever: two timeouts, FAULT at 4+32+4+32 edges, then held.
        tick(1'b0, 1'b1);
        n_hit = 0;
        for (int n = 1; n <= 200; n++) begin
            tick(1'b0, 1'b0);
            if (bus.fault) begin n_hit = n; break; end
        end
        chk("fault_edge", n_hit, 2 * (RP + TO));
        repeat (1000) tick(1'b0, 1'b0);
        chk("fault_hold", bus.fault, 1);
        chk("fault_pll_rst", bus.pll_rst, 0);
        chk("fault_sys_rst", bus.sys_rst, 1);
        chk("fault_retry", bus.retry_count, MR);
        tick(1'b0, 1'b1);
        chk_reset_vals("rst_fault");

        // Randomized lock traffic with occasional resets.
        for (int s = 0; s < 40; s++) begin
            logic lv;
            int   dur;
            lv  = 1'($urandom_range(0, 1));
            dur = (lv && $urandom_range(0, 2) == 0) ? $urandom_range(ST, 3 * ST)
                                                     : $urandom_range(1, 40);
            for (int c = 0; c < dur; c++)
                tick(lv, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
